// File: rtl/adc8_convst_responder.sv
// Responder end of an 8-bit ADC CONVST/EOC handshake: it samples a value on a CONVST rising
// edge, waits the conversion time, then presents the result and pulses EOC active-low.
module adc8_convst_responder #(
  parameter int CONV_CYCLES  = 60,
  parameter int SETUP_CYCLES = 2,
  parameter int EOC_CYCLES   = 10,
  parameter int CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_convst,
  input  logic [7:0]       i_sample,
  output logic [7:0]       o_data,
  output logic             o_eoc,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SETUP   = 2'd2,
    EOC     = 2'd3
  } state_t;

  localparam int MAX_CYC = (CONV_CYCLES > SETUP_CYCLES)
                         ? ((CONV_CYCLES > EOC_CYCLES) ? CONV_CYCLES : EOC_CYCLES)
                         : ((SETUP_CYCLES > EOC_CYCLES) ? SETUP_CYCLES : EOC_CYCLES);
  localparam int PH_W = $clog2(MAX_CYC + 1);

  // The detection cycle is the first conversion cycle, so CONVERT itself lasts one cycle less.
  // This puts o_data at detection+CONV_CYCLES rather than one cycle later.
  localparam logic [PH_W-1:0] CONV_LAST  = PH_W'((CONV_CYCLES > 1) ? CONV_CYCLES - 2 : 0);
  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] EOC_LAST   = PH_W'(EOC_CYCLES - 1);

  logic            r_s1, r_s2, r_s3;
  logic            w_rise;
  state_t          r_state, w_next_state;
  logic [PH_W-1:0] r_phase, w_next_phase;
  logic [7:0]      r_result;
  logic            w_accept;
  logic            w_load_data;
  logic            w_overrun;

  assign w_rise = r_s2 & ~r_s3;

  // NOTE: always_comb assigns every output a default before the case; otherwise latches are inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase + PH_W'(1);
    w_accept     = 1'b0;
    w_load_data  = 1'b0;
    w_overrun    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_next_phase = '0;
        if (w_rise) begin
          w_accept = 1'b1;
          if (CONV_CYCLES == 1) begin
            w_load_data  = 1'b1;
            w_next_state = SETUP;
          end else begin
            w_next_state = CONVERT;
          end
        end
      end
      CONVERT: begin
        w_overrun = w_rise;
        if (r_phase == CONV_LAST) begin
          w_load_data  = 1'b1;
          w_next_phase = '0;
          w_next_state = SETUP;
        end
      end
      SETUP: begin
        w_overrun = w_rise;
        if (r_phase == SETUP_LAST) begin
          w_next_phase = '0;
          w_next_state = EOC;
        end
      end
      EOC: begin
        w_overrun = w_rise;
        if (r_phase == EOC_LAST) begin
          w_next_phase = '0;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_phase = '0;
        w_next_state = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // Synchroniser resets high so a CONVST already high cannot look like a fresh edge.
      r_s1          <= 1'b1;
      r_s2          <= 1'b1;
      r_s3          <= 1'b1;
      r_state       <= IDLE;
      r_phase       <= '0;
      r_result      <= '0;
      o_data        <= '0;
      o_eoc         <= 1'b1;
      o_busy        <= 1'b0;
      o_overrun_cnt <= '0;
    end else begin
      r_s1    <= i_convst;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_next_state;
      r_phase <= w_next_phase;
      if (w_accept) begin
        r_result <= i_sample;
      end
      if (w_load_data) begin
        o_data <= w_accept ? i_sample : r_result;
      end
      o_eoc <= (w_next_state != EOC);
      // Busy spans the accept cycle's successor through the cycle EOC returns high.
      o_busy <= (r_state != IDLE) || (w_next_state != IDLE);
      if (w_overrun && (o_overrun_cnt != '1)) begin
        o_overrun_cnt <= o_overrun_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc8_convst_responder.sv
// Randomised bench for adc8_convst_responder: a cycle-indexed reference model predicts every
// output; a scoreboard queue pairs each accepted conversion with its EOC falling edge.
module tb_adc8_convst_responder;

  localparam int CONV   = 60;
  localparam int SETUP  = 2;
  localparam int EOCN   = 10;
  localparam int TOTAL  = CONV + SETUP + EOCN;
  localparam int NCYC   = 40000;
  localparam int SATMAX = 255;

  typedef struct {
    logic [7:0] data;
    int         fall_cycle;
  } conv_t;

  logic       clk;
  logic       i_reset;
  logic       i_convst;
  logic [7:0] i_sample;
  logic [7:0] o_data;
  logic       o_eoc;
  logic       o_busy;
  logic [7:0] o_overrun_cnt;

  adc8_convst_responder #(
    .CONV_CYCLES (CONV),
    .SETUP_CYCLES(SETUP),
    .EOC_CYCLES  (EOCN),
    .CNT_W       (8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_convst     (i_convst),
    .i_sample     (i_sample),
    .o_data       (o_data),
    .o_eoc        (o_eoc),
    .o_busy       (o_busy),
    .o_overrun_cnt(o_overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    eff_conv [NCYC];
  conv_t sb_q[$];

  // Reference model state, in terms of the most recent accepted conversion.
  bit         checking   = 1'b0;
  bit         act_valid  = 1'b0;
  int         act_d      = 0;
  logic [7:0] act_sample = '0;
  logic [7:0] prev_data  = '0;
  int         free_from  = 0;
  int         model_cnt  = 0;
  int         over_total = 0;
  logic       exp_busy, exp_eoc;
  logic [7:0] exp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // A rise is seen two cycles after the pin went high, provided it was low the cycle before.
  function automatic bit rise_at(input int c);
    if (c < 3) return 1'b0;
    return eff_conv[c-2] && !eff_conv[c-3];
  endfunction

  always @(posedge clk) begin
    int c;
    int t;
    c = cyc;
    eff_conv[c] = i_convst;
    if (i_reset) begin
      for (int k = 0; k < 3; k++) if (c - k >= 0) eff_conv[c-k] = 1'b1;
      checking  = 1'b1;
      act_valid = 1'b0;
      prev_data = '0;
      free_from = 0;
      model_cnt = 0;
      sb_q.delete();
    end else if (rise_at(c)) begin
      if (c >= free_from) begin
        conv_t e;
        if (act_valid) prev_data = act_sample;
        act_valid  = 1'b1;
        act_d      = c;
        act_sample = i_sample;
        free_from  = c + TOTAL;
        e.data       = i_sample;
        e.fall_cycle = c + CONV + SETUP;
        sb_q.push_back(e);
      end else begin
        over_total++;
        if (model_cnt < SATMAX) model_cnt++;
      end
    end
    cyc = c + 1;
    t = cyc;
    exp_busy = act_valid && (t >= act_d + 1) && (t <= act_d + TOTAL);
    exp_eoc  = !(act_valid && (t >= act_d + CONV + SETUP) && (t < act_d + TOTAL));
    exp_data = (act_valid && (t >= act_d + CONV)) ? act_sample : prev_data;
  end

  // Monitor: per-cycle output comparison plus scoreboard pop on each EOC falling edge.
  logic prev_eoc = 1'b1;
  always @(negedge clk) begin
    if (checking) begin
      check("busy", 32'(o_busy), 32'(exp_busy));
      check("eoc", 32'(o_eoc), 32'(exp_eoc));
      check("data", 32'(o_data), 32'(exp_data));
      check("overrun_cnt", 32'(o_overrun_cnt), 32'(model_cnt));
      if (prev_eoc === 1'b1 && o_eoc === 1'b0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_eoc_fall", 32'(1), 32'(0));
        end else begin
          conv_t e;
          e = sb_q.pop_front();
          check("eoc_data", 32'(o_data), 32'(e.data));
          check("eoc_fall_cycle", 32'(cyc), 32'(e.fall_cycle));
        end
      end
      prev_eoc = o_eoc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    i_reset  = 1'b1;
    i_convst = 1'b0;
    i_sample = 8'h00;
    tick(3);
    i_reset = 1'b0;
    tick(5);

    // Basic conversion, 20-cycle strobe.
    i_sample = 8'hA5; i_convst = 1'b1; tick(20);
    i_convst = 1'b0; tick(90);

    // Sample changes five cycles after detection; the latched value must win.
    i_sample = 8'h3C; i_convst = 1'b1; tick(7);
    i_sample = 8'hFF; tick(13);
    i_convst = 1'b0; tick(90);

    // Second rise detected 30 cycles into a conversion.
    i_sample = 8'h5A; i_convst = 1'b1; tick(20);
    i_convst = 1'b0; tick(10);
    i_sample = 8'h00; i_convst = 1'b1; tick(5);
    i_convst = 1'b0; tick(90);

    // Rise detected on the last EOC cycle is an overrun.
    i_sample = 8'h81; i_convst = 1'b1; tick(3);
    i_convst = 1'b0; tick(68);
    i_convst = 1'b1; tick(1);
    i_convst = 1'b0; tick(10);

    // Rise detected on the first IDLE cycle starts a new conversion.
    i_sample = 8'hC3; i_convst = 1'b1; tick(3);
    i_convst = 1'b0; tick(69);
    i_sample = 8'h77; i_convst = 1'b1; tick(1);
    i_convst = 1'b0; tick(140);

    // Reset 40 cycles after detection discards the conversion.
    i_sample = 8'h99; i_convst = 1'b1; tick(20);
    i_convst = 1'b0; tick(22);
    i_reset = 1'b1; tick(1);
    i_reset = 1'b0; tick(100);

    // CONVST held high through reset must not trigger.
    i_convst = 1'b1; i_reset = 1'b1; tick(3);
    i_reset = 1'b0; tick(100);
    i_convst = 1'b0; tick(3);
    i_sample = 8'hE7; i_convst = 1'b1; tick(5);
    i_convst = 1'b0; tick(90);

    // Random strobes until the overrun counter has been pushed well past saturation.
    for (int it = 0; it < 4000 && over_total < 330; it++) begin
      i_sample = 8'($urandom);
      i_convst = 1'b1;
      tick($urandom_range(1, 3));
      i_sample = 8'($urandom);
      i_convst = 1'b0;
      tick($urandom_range(1, 3));
    end
    tick(100);
    @(negedge clk);
    check("overrun_saturated", 32'(o_overrun_cnt), 32'(SATMAX));

    for (int w = 0; w < 200 && sb_q.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc8_convst_responder.md
Name: adc8_convst_responder

Overview:
- Emulates the 8-bit rectifier-side ADC, the responder end of the CONVST/EOC interface used for battery voltage/current acquisition.
- Accepts a conversion-start strobe, waits a programmable conversion time, drives the 8-bit result, then pulses EOC active-low.
- Used for bench/loopback testing of the acquisition path: one FPGA drives CONVST and latches data on the EOC falling edge; this block answers on EX header pins.

Parameters:
- CONV_CYCLES, 60, i_clk cycles spent in CONVERT (≥1).
- SETUP_CYCLES, 2, cycles o_data is stable before o_eoc falls (≥1).
- EOC_CYCLES, 10, cycles o_eoc is held low (≥1).
- CNT_W, 8, width of the saturating overrun counter.

Ports:
- i_clk  in  1  system clock (100 MHz in target build).
- i_reset  in  1  synchronous, active-high reset.
- i_convst  in  1  conversion start from initiator; asynchronous to i_clk; a rising edge triggers a conversion.
- i_sample  in  8  value to be "converted"; sampled when the trigger is accepted.
- o_data  out  8  conversion result; stable from SETUP entry until the next result load.
- o_eoc  out  1  end-of-conversion, active-low; idle high.
- o_busy  out  1  high in any state other than IDLE.
- o_overrun_cnt  out  CNT_W  count of triggers ignored while busy; saturating.

Behaviour:
- Reset values: o_data=0, o_eoc=1, o_busy=0, o_overrun_cnt=0, state=IDLE, phase counter=0, sync flops s1/s2/s3=1.
  - Sync flops reset high so a CONVST held high through reset does not fire a trigger.
- Synchroniser: s1<=i_convst, s2<=s1, s3<=s2. Trigger rise = s2 & ~s3. Trigger detected 2–3 cycles after the i_convst edge.
- FSM states: IDLE, CONVERT, SETUP, EOC.
  - IDLE: on rise, latch i_sample into an internal result register, clear the phase counter, go to CONVERT. o_busy rises the cycle after detection.
  - CONVERT: count CONV_CYCLES cycles. On the last one, load o_data from the result register and go to SETUP.
  - SETUP: count SETUP_CYCLES cycles; o_eoc stays 1. On the last one, go to EOC.
  - EOC: o_eoc=0 for exactly EOC_CYCLES cycles. On the last one, go to IDLE; o_eoc returns to 1 on IDLE entry.
- Latency from the detection cycle (cycle 0):
  - o_data updates at cycle CONV_CYCLES.
  - o_eoc falls at cycle CONV_CYCLES+SETUP_CYCLES.
  - o_eoc rises at cycle CONV_CYCLES+SETUP_CYCLES+EOC_CYCLES.
- o_data hold: unchanged through EOC and IDLE until the next CONVERT completes, so the initiator's falling-edge latch always sees stable data.
- Changes to i_sample after the latch do not affect the in-flight result.
- Overrun: a rise detected in CONVERT, SETUP or EOC is ignored (no restart, no re-latch) and increments o_overrun_cnt. The counter saturates at all-ones.
- Same-cycle boundary: a rise on the last EOC cycle counts as an overrun; a rise in the first IDLE cycle is accepted.
- i_convst held high: exactly one conversion; a new one needs a low-then-high transition.
- Glitches shorter than one i_clk period may be missed; this is acceptable.
- Reset mid-operation: immediately returns all outputs to reset values. The in-flight conversion is discarded, no EOC pulse is emitted, and o_data is cleared.
- All outputs are registered (no combinational path from inputs).

Test Plan:
- Basic conversion: i_sample=0xA5, one CONVST pulse 20 cycles wide, defaults.
  - o_data=0xA5 at detection+60.
  - o_eoc low from detection+62 to detection+71, high at +72.
  - o_busy high for cycles +1..+72; o_overrun_cnt=0.
- Sample latch: i_sample=0x3C at trigger, changed to 0xFF at detection+5 → o_data=0x3C at the EOC fall.
- Overrun: second CONVST rise detected at +30 → no restart, timing identical to the basic case, o_overrun_cnt=1. Then 300 busy-time triggers across repeated conversions → o_overrun_cnt saturates at 255.
- Boundary: a rise on the last EOC cycle → ignored, count +1. A rise detected on the first IDLE cycle → new conversion, EOC fall 62 cycles later.
- Reset mid-op: i_reset asserted at detection+40 for 1 cycle → next cycle o_eoc=1, o_busy=0, o_data=0, o_overrun_cnt=0; no EOC pulse follows.
- Reset with CONVST high: i_convst=1 throughout reset and after → no conversion. A later low→high transition starts a conversion normally.
